griffin_sponge_ctrl: RTL
========================

Name: griffin_sponge_ctrl

Overview:
- Sponge-mode controller directly upstream and downstream of the Griffin permutation wrapper; hashes a variable-length stream of field elements into one field-element digest.
- Absorbs message elements into the rate lanes by addition modulo PRIME_MODULUS.
- Drives the wrapper's word-serial write/enable/read interface once per block and reads the permuted state back.
- Emits lane 0 of the final state as the digest over a valid/ready handshake.

Parameters:
- N_BITS, 254, field element width.
- PRIME_MODULUS, BN254 scalar prime (254'h30644e72...f0000001), modulus for absorb additions.
- STATE_SIZE, 3, permutation width in elements.
- RATE, 2, rate lanes; must satisfy 1 <= RATE < STATE_SIZE.
- IV, 0, initial value of every state lane.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- msg_data  in  N_BITS  message element, required < PRIME_MODULUS
- msg_valid  in  1  msg_data valid
- msg_last  in  1  final element of the message
- msg_ready  out  1  element accepted when msg_valid & msg_ready
- digest  out  N_BITS  hash result
- digest_valid  out  1  digest valid, held until accepted
- digest_ready  in  1  consumer accepts digest
- busy  out  1  high in every state except IDLE
- perm_rst  out  1  synchronous reset to the permutation wrapper
- perm_wr  out  1  write strobe, one state word per cycle
- perm_in  out  N_BITS  state word, lane order 0..STATE_SIZE-1
- perm_en  out  1  permutation enable
- perm_done  in  1  permutation complete
- perm_rd  out  1  read strobe
- perm_out  in  N_BITS  state word; valid the cycle after each perm_rd

Behaviour:
- Reset values:
  - state lanes = IV; FSM = IDLE.
  - msg_ready = 0, digest = 0, digest_valid = 0, busy = 0, perm_wr = perm_en = perm_rd = 0.
  - perm_rst = 1 while reset is high.
  - Reset mid-operation aborts everything: no partial digest, state restored to IV.
- FSM states and transitions:
  - IDLE: msg_ready = 1. The first accepted element moves to ABSORB with lane = 0.
  - ABSORB: msg_ready = 1. Each accept does state[lane] <= modadd(state[lane], msg_data), then lane++.
    - If lane reaches RATE, or msg_last is accepted, go to PRST.
    - pad_pending = msg_last. pad_lane = lane+1 if that is < RATE, otherwise lane 0 of a fresh block that needs its own permutation.
    - When pad_lane is in the current block, state[pad_lane] += 1 happens in the single PAD cycle before PRST.
  - PAD: one cycle, state[pad_lane] <= modadd(state[pad_lane], 1), then PRST.
  - PRST: perm_rst = 1 for exactly 1 cycle; clears the wrapper's write/read pointers. Required before every permutation.
  - LOAD: perm_wr = 1 for STATE_SIZE consecutive cycles, perm_in = state[0..STATE_SIZE-1].
  - RUN: perm_en held high until perm_done = 1, then READ.
  - READ: perm_rd = 1 for STATE_SIZE cycles. perm_out is captured into state[i] one cycle after rd i, so READ lasts STATE_SIZE+1 cycles.
  - After READ:
    - If more input is expected (no msg_last seen), go to ABSORB.
    - If padding is still owed in a new block, go to PAD with pad_lane = 0.
    - Otherwise go to OUT.
  - OUT: digest = state[0], digest_valid = 1 until digest_ready. On the handshake, state <= IV and go to IDLE.
- msg_ready is 0 in PAD/PRST/LOAD/RUN/READ/OUT. msg_valid without msg_ready is simply stalled.
- modadd(a,b): s = a+b in N_BITS+1 bits; result = s >= PRIME_MODULUS ? s-PRIME_MODULUS : s. Combinational, single cycle.
- Latency per block: RATE absorb cycles (at full msg rate) + 1 PRST + STATE_SIZE LOAD + permutation latency + STATE_SIZE+1 READ. Add 1 PAD cycle when padding lands in the current block.
- Capacity lanes (RATE..STATE_SIZE-1) are never written by absorb or pad.
- digest_ready asserted outside OUT is ignored.

Optional Feature:
- Macro GRIFFIN_SPONGE_RANGE_CHECK_EN.
- Defined:
  - Adds output port msg_err (1 bit).
  - An element with msg_data >= PRIME_MODULUS is accepted (handshake completes) but not added to state.
  - msg_err pulses 1 cycle; the message still completes, and the digest is forced to 0 with an error-sticky bit cleared at IDLE.
- Undefined: no port, no compare. Inputs >= PRIME_MODULUS are a caller contract violation and the result is unspecified.

Decomposition:
- Package griffin_sponge_pkg holds:
  - the FSM state enum (IDLE, ABSORB, PAD, PRST, LOAD, RUN, READ, OUT);
  - default BN254 PRIME_MODULUS / N_BITS constants;
  - modadd as a function.
- One sub-module: griffin_modadd (pure combinational modular adder), instanced once and shared by absorb and pad through a lane/operand mux.

Test Plan:
- All tests use a stub permutation: identity, latency 5, wrapper pointer semantics. Tests 1-4 and 6 assume the macro is undefined.
1. Message [5] -> state [5,1,0] permuted once; digest = 5; exactly 1 perm_rst pulse, 3 perm_wr, 3 perm_rd.
2. Message [7,9] (full block) -> two permutations, second after pad at lane 0; digest = 8.
3. Message [p-1,3] -> pad wraps lane 0: (p-1)+1 = 0; digest = 0 (tests modular wrap).
4. msg_valid gaps and digest_ready held low 10 cycles -> digest_valid stays high with a stable value; msg_ready = 0 throughout OUT.
5. With the macro defined: message [p, 4] -> msg_err pulse on the first element; digest = 0.
6. Reset asserted during RUN -> next cycle busy = 0, perm_rst = 1, all state lanes = IV. Re-sending message [5] gives digest 5.

Source files
------------

// File: rtl/griffin_sponge_pkg.sv
// Shared definitions for the Griffin sponge controller: FSM state encoding,
// default BN254 field constants and a reference modular adder.
package griffin_sponge_pkg;

    localparam int unsigned N_BITS_DEF = 254;
    localparam logic [N_BITS_DEF-1:0] PRIME_DEF =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        PRST,
        LOAD,
        RUN,
        READ,
        OUT
    } sponge_state_t;

    // (a + b) mod PRIME_DEF for operands already reduced below PRIME_DEF
    function automatic logic [N_BITS_DEF-1:0] modadd(
        input logic [N_BITS_DEF-1:0] a,
        input logic [N_BITS_DEF-1:0] b
    );
        logic [N_BITS_DEF:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, PRIME_DEF}) begin
            s = s - {1'b0, PRIME_DEF};
        end
        return s[N_BITS_DEF-1:0];
    endfunction

endpackage

// File: rtl/griffin_modadd.sv
// Combinational modular adder: sum_c = (a + b) mod PRIME_MODULUS.
// Ports:
//   a, b   in   N_BITS  operands, each < PRIME_MODULUS
//   sum_c  out  N_BITS  reduced sum (combinational)
module griffin_modadd
    import griffin_sponge_pkg::*;
#(
    parameter int unsigned         N_BITS        = N_BITS_DEF,
    parameter logic [N_BITS-1:0]   PRIME_MODULUS = N_BITS'(PRIME_DEF)
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] sum_c
);

    localparam int unsigned SUM_W = N_BITS + 1;

    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] p_ext;

    // One extra bit keeps the carry so a single conditional subtract reduces
    assign s     = {1'b0, a} + {1'b0, b};
    assign p_ext = {1'b0, PRIME_MODULUS};
    assign sum_c = (s >= p_ext) ? N_BITS'(s - p_ext) : s[N_BITS-1:0];

endmodule

// File: rtl/griffin_sponge_ctrl.sv
// Sponge-mode controller around the Griffin permutation wrapper. Absorbs a
// stream of field elements into the rate lanes (modular add), pads with a
// single +1, runs the wrapper word-serially per block and emits lane 0 of the
// final state as the digest.
// Optional: GRIFFIN_SPONGE_RANGE_CHECK_EN adds msg_err; out-of-field elements
// are accepted but dropped, and the digest of that message is forced to 0.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   msg_data/valid/last/ready   message element stream
//   msg_err                     (optional) pulse on an out-of-field element
//   digest/valid/ready          digest handshake
//   busy                        high outside IDLE
//   perm_rst/wr/in/en/rd        controls toward the permutation wrapper
//   perm_done/out               status and read data from the wrapper
module griffin_sponge_ctrl
    import griffin_sponge_pkg::*;
#(
    parameter int unsigned         N_BITS        = N_BITS_DEF,
    parameter logic [N_BITS-1:0]   PRIME_MODULUS = N_BITS'(PRIME_DEF),
    parameter int unsigned         STATE_SIZE    = 3,
    parameter int unsigned         RATE          = 2,
    parameter logic [N_BITS-1:0]   IV            = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] msg_data,
    input  logic              msg_valid,
    input  logic              msg_last,
    output logic              msg_ready,
`ifdef GRIFFIN_SPONGE_RANGE_CHECK_EN
    output logic              msg_err,
`endif
    output logic [N_BITS-1:0] digest,
    output logic              digest_valid,
    input  logic              digest_ready,
    output logic              busy,
    output logic              perm_rst,
    output logic              perm_wr,
    output logic [N_BITS-1:0] perm_in,
    output logic              perm_en,
    input  logic              perm_done,
    output logic              perm_rd,
    input  logic [N_BITS-1:0] perm_out
);

    localparam int unsigned LANE_W = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
    localparam int unsigned CNT_W  = $clog2(STATE_SIZE + 1);

    sponge_state_t     fsm;
    logic [N_BITS-1:0] lanes [STATE_SIZE];
    logic [LANE_W-1:0] lane_idx;
    logic [LANE_W-1:0] pad_lane;
    logic [CNT_W-1:0]  cnt;
    logic              last_seen;
    logic              pad_owed;

    logic              accept_c;
    logic [LANE_W-1:0] lane_nxt_c;
    logic [LANE_W-1:0] add_lane_c;
    logic [N_BITS-1:0] add_a_c;
    logic [N_BITS-1:0] add_b_c;
    logic [N_BITS-1:0] add_sum_c;
    logic              elem_bad_c;
    logic              digest_zero_c;

    assign accept_c   = msg_valid & msg_ready & ((fsm == IDLE) | (fsm == ABSORB));
    assign lane_nxt_c = lane_idx + LANE_W'(1);

    // Shared adder: PAD adds 1 at pad_lane, otherwise absorb msg_data at lane_idx
    always_comb begin
        add_lane_c = lane_idx;
        add_b_c    = msg_data;
        if (fsm == PAD) begin
            add_lane_c = pad_lane;
            add_b_c    = N_BITS'(1);
        end
    end

    assign add_a_c = lanes[add_lane_c];

    griffin_modadd #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS)
    ) u_modadd (
        .a     (add_a_c),
        .b     (add_b_c),
        .sum_c (add_sum_c)
    );

`ifdef GRIFFIN_SPONGE_RANGE_CHECK_EN
    logic err_sticky;

    assign elem_bad_c    = (msg_data >= PRIME_MODULUS);
    assign digest_zero_c = err_sticky;

    // Error pulse and per-message sticky flag; sticky clears once back in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            msg_err <= accept_c & elem_bad_c;
            if (accept_c && elem_bad_c) begin
                err_sticky <= 1'b1;
            end else if (fsm == IDLE) begin
                err_sticky <= 1'b0;
            end
        end
    end
`else
    assign elem_bad_c    = 1'b0;
    assign digest_zero_c = 1'b0;
`endif

    // Sponge FSM with registered outputs set on each transition
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm          <= IDLE;
            for (int unsigned i = 0; i < STATE_SIZE; i++) begin
                lanes[i] <= IV;
            end
            lane_idx     <= '0;
            pad_lane     <= '0;
            cnt          <= '0;
            last_seen    <= 1'b0;
            pad_owed     <= 1'b0;
            msg_ready    <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            perm_rst     <= 1'b1;
            perm_wr      <= 1'b0;
            perm_in      <= '0;
            perm_en      <= 1'b0;
            perm_rd      <= 1'b0;
        end else begin
            case (fsm)
                IDLE, ABSORB: begin
                    msg_ready <= 1'b1;
                    perm_rst  <= 1'b0;
                    if (accept_c) begin
                        busy <= 1'b1;
                        if (!elem_bad_c) begin
                            lanes[lane_idx] <= add_sum_c;
                        end
                        if (msg_last) begin
                            last_seen <= 1'b1;
                            msg_ready <= 1'b0;
                            lane_idx  <= '0;
                            // Pad lands in this block, or needs a block of its own
                            if (lane_nxt_c < LANE_W'(RATE)) begin
                                pad_lane <= lane_nxt_c;
                                fsm      <= PAD;
                            end else begin
                                pad_owed <= 1'b1;
                                perm_rst <= 1'b1;
                                fsm      <= PRST;
                            end
                        end else if (lane_nxt_c == LANE_W'(RATE)) begin
                            msg_ready <= 1'b0;
                            lane_idx  <= '0;
                            perm_rst  <= 1'b1;
                            fsm       <= PRST;
                        end else begin
                            lane_idx <= lane_nxt_c;
                            fsm      <= ABSORB;
                        end
                    end
                end

                PAD: begin
                    lanes[pad_lane] <= add_sum_c;
                    perm_rst        <= 1'b1;
                    fsm             <= PRST;
                end

                PRST: begin
                    perm_rst <= 1'b0;
                    perm_wr  <= 1'b1;
                    perm_in  <= lanes[0];
                    cnt      <= CNT_W'(1);
                    fsm      <= LOAD;
                end

                LOAD: begin
                    if (cnt == CNT_W'(STATE_SIZE)) begin
                        perm_wr <= 1'b0;
                        perm_en <= 1'b1;
                        fsm     <= RUN;
                    end else begin
                        perm_in <= lanes[cnt];
                        cnt     <= cnt + CNT_W'(1);
                    end
                end

                RUN: begin
                    if (perm_done) begin
                        perm_en <= 1'b0;
                        perm_rd <= 1'b1;
                        cnt     <= '0;
                        fsm     <= READ;
                    end
                end

                // perm_out for read i arrives one cycle later, so capture lags by one
                READ: begin
                    if (cnt != '0) begin
                        lanes[cnt - CNT_W'(1)] <= perm_out;
                    end
                    perm_rd <= (cnt < CNT_W'(STATE_SIZE - 1));
                    if (cnt == CNT_W'(STATE_SIZE)) begin
                        if (!last_seen) begin
                            msg_ready <= 1'b1;
                            fsm       <= ABSORB;
                        end else if (pad_owed) begin
                            pad_owed <= 1'b0;
                            pad_lane <= '0;
                            fsm      <= PAD;
                        end else begin
                            digest       <= digest_zero_c ? '0 : lanes[0];
                            digest_valid <= 1'b1;
                            fsm          <= OUT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                OUT: begin
                    if (digest_ready) begin
                        for (int unsigned i = 0; i < STATE_SIZE; i++) begin
                            lanes[i] <= IV;
                        end
                        digest_valid <= 1'b0;
                        last_seen    <= 1'b0;
                        busy         <= 1'b0;
                        msg_ready    <= 1'b1;
                        fsm          <= IDLE;
                    end
                end

                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
